// File: rtl/div_pkg.sv
`default_nettype none
// =============================================================================
// Module   : div_pkg
// Purpose  : Shared op encodings, FSM states and sizing helper for div.
// Revision : 1.0
// =============================================================================
package div_pkg;

  // Matches the mul unit's is_signed convention.
  localparam logic OP_DIVU = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// =============================================================================
// Module   : div
// Purpose  : Iterative radix-2 restoring DIV/DIVU; quotient on lo, remainder on hi.
// Revision : 1.0
// =============================================================================
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] opa_q;
  logic [CNT_W-1:0] cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;

  logic [WIDTH:0]   rem_sh;
  logic             qbit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             a_neg;
  logic             b_neg;

  assign a_neg = (op == OP_DIV) & opA[WIDTH-1];
  assign b_neg = (op == OP_DIV) & opB[WIDTH-1];

  // The kept remainder is always below the divisor, so W bits hold it; only
  // the shifted trial value needs the extra bit.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    qbit   = (rem_sh >= {1'b0, dsr_q});
    rem_d  = qbit ? (rem_sh[WIDTH-1:0] - dsr_q) : rem_sh[WIDTH-1:0];
    dvd_d  = {dvd_q[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      opa_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            dz_q    <= (opB == '0);
            opa_q   <= opA;
            dvd_q   <= a_neg ? -opA : opA;
            dsr_q   <= b_neg ? -opB : opB;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (dz_q) begin
            lo_q <= '1;
            hi_q <= opa_q;
          end else begin
            lo_q <= qneg_q ? -dvd_q : dvd_q;
            hi_q <= rneg_q ? -rem_q : rem_q;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire
